// File: rtl/and3_shared_sequencer_pkg.sv
// Shared types and helpers for the time-multiplexed three-input AND sequencer.
package and3_shared_sequencer_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StPass1 = 2'd1,
      StPass2 = 2'd2,
      StResp  = 2'd3
   } state_e;

   // Index width for n requesters, never narrower than one bit.
   function automatic int unsigned id_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/and3_shared_sequencer_if.sv
// Requester-side and result-side signal bundle of the shared AND sequencer.
interface and3_shared_sequencer_if
   import and3_shared_sequencer_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned ID_W = id_width(N_REQ);

   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] a_in;
   logic [N_REQ*WIDTH-1:0] b_in;
   logic [N_REQ*WIDTH-1:0] c_in;
   logic [N_REQ-1:0]       grant;
   logic                   busy;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       d_out;
   logic [WIDTH-1:0]       e_out;
   logic [ID_W-1:0]        out_id;

   modport slave (
      input  req, a_in, b_in, c_in, out_ready,
      output grant, busy, out_valid, d_out, e_out, out_id
   );

   modport master (
      output req, a_in, b_in, c_in, out_ready,
      input  grant, busy, out_valid, d_out, e_out, out_id
   );

endinterface

// File: rtl/and3_shared_sequencer_rr_pick.sv
// Combinational round-robin picker: first set request after last_winner, wrapping.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  last_winner_i,
   output logic             any_o,
   output logic [ID_W-1:0]  winner_o
);

   int idx;

   // Scan from the farthest offset down so the nearest set bit is written last and wins.
   always_comb begin
      any_o    = 1'b0;
      winner_o = '0;
      idx      = 0;
      for (int k = int'(N_REQ); k >= 1; k--) begin
         idx = (int'(last_winner_i) + k) % int'(N_REQ);
         if (req_i[idx]) begin
            any_o    = 1'b1;
            winner_o = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/and3_shared_sequencer.sv
// One bitwise AND stage shared round-robin among N_REQ requesters; each job is
// two passes (d = a & b, e = d & c) with the result held until the consumer takes it.
module and3_shared_sequencer
   import and3_shared_sequencer_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   and3_shared_sequencer_if.slave bus
);

   localparam int unsigned ID_W = id_width(N_REQ);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
   logic [WIDTH-1:0] d_q, d_d, e_q, e_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [ID_W-1:0]  last_q, last_d;
   logic [N_REQ-1:0] grant_q, grant_d;

   logic             pick_any;
   logic [ID_W-1:0]  pick_winner;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_pick (
      .req_i         (bus.req),
      .last_winner_i (last_q),
      .any_o         (pick_any),
      .winner_o      (pick_winner)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      e_d     = e_q;
      id_d    = id_q;
      last_d  = last_q;
      grant_d = '0;
      case (state_q)
         StIdle: begin
            if (pick_any) begin
               a_d              = bus.a_in[int'(pick_winner)*WIDTH +: WIDTH];
               b_d              = bus.b_in[int'(pick_winner)*WIDTH +: WIDTH];
               c_d              = bus.c_in[int'(pick_winner)*WIDTH +: WIDTH];
               id_d             = pick_winner;
               last_d           = pick_winner;
               grant_d[pick_winner] = 1'b1;
               state_d          = StPass1;
            end
         end
         StPass1: begin
            d_d     = a_q & b_q;
            state_d = StPass2;
         end
         StPass2: begin
            e_d     = d_q & c_q;
            state_d = StResp;
         end
         StResp: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Priority starts at requester 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         e_q     <= '0;
         id_q    <= '0;
         last_q  <= ID_W'(N_REQ - 1);
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         e_q     <= e_d;
         id_q    <= id_d;
         last_q  <= last_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      bus.grant     = grant_q;
      bus.busy      = (state_q != StIdle);
      bus.out_valid = (state_q == StResp);
      bus.d_out     = (state_q == StResp) ? d_q  : '0;
      bus.e_out     = (state_q == StResp) ? e_q  : '0;
      bus.out_id    = (state_q == StResp) ? id_q : '0;
   end

endmodule
